// File: rtl/raw2rgb_pkg.sv
// Shared constants for the Bayer-to-RGB converter: Bayer phase of the emitting
// pixel and the default geometry/width.
package raw2rgb_pkg;

    localparam int DATA_W_DEF     = 12;
    localparam int LINE_WIDTH_DEF = 1280;

    // The emitting pixel of a quad is G2, at odd column / odd row.
    localparam logic EMIT_X = 1'b1;
    localparam logic EMIT_Y = 1'b1;

    function automatic logic is_emit(input logic dval, input logic x0, input logic y0);
        return dval && (x0 == EMIT_X) && (y0 == EMIT_Y);
    endfunction

endpackage

// File: rtl/raw2rgb_line_buffer.sv
// One-row delay line: single-port read-before-write RAM addressed by a
// wrap-around counter that advances on each enabled access.
module raw2rgb_line_buffer #(
    parameter int DEPTH = 1280,
    parameter int W     = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] ptr;
    logic [AW-1:0] addr;

    // A clear redirects the current access to slot 0 so the row realigns at once.
    assign addr = clr ? '0 : ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= (addr == AW'(DEPTH - 1)) ? '0 : addr + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            rdata     <= mem[addr];
            mem[addr] <= wdata;
        end
    end

endmodule

// File: rtl/raw2rgb.sv
// Bayer (G1 R / B G2) to RGB converter, one output per 2x2 quad, with optional
// luma binarization. Two-stage pipeline: window capture, then colour/threshold.
module raw2rgb
    import raw2rgb_pkg::*;
#(
    parameter int LINE_WIDTH = LINE_WIDTH_DEF,
    parameter int DATA_W     = DATA_W_DEF
) (
    input  logic              iCLK,
    input  logic              iRST,
    input  logic [DATA_W-1:0] iDATA,
    input  logic              iDVAL,
    input  logic [15:0]       iX_Cont,
    input  logic [15:0]       iY_Cont,
    input  logic [7:0]        iThreshold,
    output logic [DATA_W-1:0] oRed,
    output logic [DATA_W-1:0] oGreen,
    output logic [DATA_W-1:0] oBlue,
    output logic              oDVAL
);

    logic              x_zero;
    logic              emit;
    logic              unused_y;

    logic [DATA_W-1:0] above;
    logic [DATA_W-1:0] left_q;
    logic [DATA_W-1:0] above_left_q;
    logic [DATA_W-1:0] s1_cur;
    logic [DATA_W-1:0] s1_left;
    logic              s1_dval;
    logic              s1_emit;

    logic [DATA_W:0]   g_sum;
    logic [DATA_W-1:0] green;
    logic [DATA_W+1:0] y_sum;
    logic [DATA_W-1:0] luma;
    logic [7:0]        luma_hi;
    logic [DATA_W-1:0] red_sel;
    logic [DATA_W-1:0] green_sel;
    logic [DATA_W-1:0] blue_sel;

    assign x_zero   = (iX_Cont == 16'd0);
    assign emit     = is_emit(iDVAL, iX_Cont[0], iY_Cont[0]);
    assign unused_y = ^iY_Cont[15:1];

    raw2rgb_line_buffer #(
        .DEPTH (LINE_WIDTH),
        .W     (DATA_W)
    ) u_line_buffer (
        .clk   (iCLK),
        .rst   (iRST),
        .en    (iDVAL),
        .clr   (x_zero),
        .wdata (iDATA),
        .rdata (above)
    );

    // Stage 1: current/left pixels captured alongside the RAM read of "above".
    // above_left_q keeps the previous pixel's RAM word, so it advances one stage late.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            left_q       <= '0;
            above_left_q <= '0;
            s1_cur       <= '0;
            s1_left      <= '0;
            s1_dval      <= 1'b0;
            s1_emit      <= 1'b0;
        end else begin
            s1_dval <= iDVAL;
            s1_emit <= emit;
            if (iDVAL) begin
                left_q  <= iDATA;
                s1_cur  <= iDATA;
                s1_left <= left_q;
            end
            if (s1_dval) begin
                above_left_q <= above;
            end
        end
    end

    always_comb begin
        g_sum   = {1'b0, above_left_q} + {1'b0, s1_cur};
        green   = g_sum[DATA_W:1];
        y_sum   = {2'b00, above} + {1'b0, green, 1'b0} + {2'b00, s1_left};
        luma    = y_sum[DATA_W+1:2];
        luma_hi = luma[DATA_W-1 -: 8];

        red_sel   = above;
        green_sel = green;
        blue_sel  = s1_left;
        if (iThreshold != 8'd0) begin
            if (luma_hi >= iThreshold) begin
                red_sel   = '1;
                green_sel = '1;
                blue_sel  = '1;
            end else begin
                red_sel   = '0;
                green_sel = '0;
                blue_sel  = '0;
            end
        end
    end

    // Stage 2: colour outputs hold between strobes.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            oRed   <= '0;
            oGreen <= '0;
            oBlue  <= '0;
            oDVAL  <= 1'b0;
        end else begin
            oDVAL <= s1_emit;
            if (s1_emit) begin
                oRed   <= red_sel;
                oGreen <= green_sel;
                oBlue  <= blue_sel;
            end
        end
    end

endmodule

// File: tb/tb_raw2rgb.sv
// Self-checking bench for raw2rgb: table-driven Bayer vectors, randomized frames
// against an image-level reference model, valid gaps, reset and short-row cases.
module tb_raw2rgb;

    localparam int LW = 1280;
    localparam int W  = 12;

    logic          iCLK = 1'b0;
    logic          iRST;
    logic [W-1:0]  iDATA;
    logic          iDVAL;
    logic [15:0]   iX_Cont;
    logic [15:0]   iY_Cont;
    logic [7:0]    iThreshold;
    logic [W-1:0]  oRed;
    logic [W-1:0]  oGreen;
    logic [W-1:0]  oBlue;
    logic          oDVAL;

    raw2rgb #(.LINE_WIDTH(LW), .DATA_W(W)) dut (
        .iCLK       (iCLK),
        .iRST       (iRST),
        .iDATA      (iDATA),
        .iDVAL      (iDVAL),
        .iX_Cont    (iX_Cont),
        .iY_Cont    (iY_Cont),
        .iThreshold (iThreshold),
        .oRed       (oRed),
        .oGreen     (oGreen),
        .oBlue      (oBlue),
        .oDVAL      (oDVAL)
    );

    // ---------------- clock / reset ----------------
    always #5 iCLK = ~iCLK;

    int cyc = 0;
    always @(posedge iCLK) cyc++;

    initial begin
        #1_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    // ---------------- bench state ----------------
    int checks = 0;
    int errors = 0;
    int strobes = 0;

    logic [36:0]  exp_q[$];      // {dont_care, r, g, b}
    int           exp_cyc[$];

    logic [11:0]  img   [4][LW];
    bit           known [4][LW];
    logic [11:0]  rnd   [4][LW];

    logic [7:0]   th;
    logic [11:0]  c_g1, c_r, c_b, c_g2;
    bit           use_tab;
    logic [35:0]  tab_rgb;
    logic [35:0]  hold_ref;
    bit           hold_known;
    bit           mon_en;

    assign iThreshold = th;

    typedef struct {
        logic [7:0]  th;
        logic [11:0] g1, r, b, g2;
        logic [11:0] er, eg, eb;
        int          len;
    } vec_t;

    vec_t tab[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [11:0] bayer(input int x, input int y);
        if (y % 2 == 0) return (x % 2 == 0) ? c_g1 : c_r;
        else            return (x % 2 == 0) ? c_b  : c_g2;
    endfunction

    function automatic logic [36:0] model_rgb(input int x, input int y);
        int r, b, g, yl;
        logic [11:0] o;
        if (!(known[y-1][x] && known[y][x-1] && known[y-1][x-1]))
            return {1'b1, 36'd0};
        r  = int'(img[y-1][x]);
        b  = int'(img[y][x-1]);
        g  = (int'(img[y-1][x-1]) + int'(img[y][x])) / 2;
        yl = (r + 2 * g + b) / 4;
        if (th == 8'd0)
            return {1'b0, 12'(r), 12'(g), 12'(b)};
        o = ((yl / 16) >= int'(th)) ? 12'hFFF : 12'h000;
        return {1'b0, o, o, o};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic idle();
        @(posedge iCLK);
        #1;
        iDVAL = 1'b0;
    endtask

    task automatic drive(input int x, input int y, input logic [11:0] v);
        @(posedge iCLK);
        #1;
        iDATA   = v;
        iX_Cont = 16'(x);
        iY_Cont = 16'(y);
        iDVAL   = 1'b1;
    endtask

    task automatic clear_frame();
        foreach (known[y, x]) known[y][x] = 1'b0;
    endtask

    task automatic feed_row(input int y, input int len, input int mode, input int gap_pct);
        logic [11:0] v;
        for (int x = 0; x < len; x++) begin
            while ($urandom_range(0, 99) < gap_pct) idle();
            v = (mode == 0) ? bayer(x, y) : rnd[y][x];
            img[y][x]   = v;
            known[y][x] = 1'b1;
            drive(x, y, v);
            if ((x % 2 == 1) && (y % 2 == 1)) begin
                if (use_tab) exp_q.push_back({1'b0, tab_rgb});
                else         exp_q.push_back(model_rgb(x, y));
                exp_cyc.push_back(cyc + 2);
            end
        end
    endtask

    task automatic drain();
        idle();
        for (int i = 0; i < 10; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge iCLK);
            #1;
        end
        check("drain_pending", exp_q.size(), 0);
        exp_q.delete();
        exp_cyc.delete();
    endtask

    // ---------------- scoreboard / monitor ----------------
    always @(negedge iCLK) begin
        if (mon_en) begin
            if (oDVAL) begin
                logic [36:0] e;
                int          c;
                strobes++;
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    c = exp_cyc.pop_front();
                    check("latency", cyc, c);
                    if (!e[36]) check("rgb", {oRed, oGreen, oBlue}, e[35:0]);
                    hold_ref   = e[35:0];
                    hold_known = !e[36];
                end
            end else if (hold_known) begin
                check("hold", {oRed, oGreen, oBlue}, hold_ref);
            end
        end
    end

    // ---------------- test sequence ----------------
    initial begin
        int s0, n_nogap, n_gap;

        iRST = 1'b1; iDATA = '0; iDVAL = 1'b0; iX_Cont = '0; iY_Cont = '0;
        th = 8'd0; use_tab = 1'b0; hold_known = 1'b0; mon_en = 1'b0;
        c_g1 = '0; c_r = '0; c_b = '0; c_g2 = '0;
        foreach (rnd[y, x]) rnd[y][x] = 12'($urandom_range(0, 4095));

        repeat (3) @(posedge iCLK);
        #1;
        check("reset_dval", oDVAL, 0);
        check("reset_rgb", {oRed, oGreen, oBlue}, 36'd0);
        iRST = 1'b0;
        hold_ref = '0; hold_known = 1'b1; mon_en = 1'b1;

        // Table: {th, G1, R, B, G2, expected R, G, B, row length}
        tab[0] = '{8'd0,   12'd100,  12'd800,  12'd400,  12'd300,  12'd800,  12'd200,  12'd400,  LW};
        tab[1] = '{8'd24,  12'd100,  12'd800,  12'd400,  12'd300,  12'hFFF,  12'hFFF,  12'hFFF,  64};
        tab[2] = '{8'd25,  12'd100,  12'd800,  12'd400,  12'd300,  12'hFFF,  12'hFFF,  12'hFFF,  64};
        tab[3] = '{8'd26,  12'd100,  12'd800,  12'd400,  12'd300,  12'h000,  12'h000,  12'h000,  64};
        tab[4] = '{8'd0,   12'd4095, 12'd1,    12'd2,    12'd4094, 12'd1,    12'd4094, 12'd2,    64};
        tab[5] = '{8'd255, 12'd4095, 12'd4095, 12'd4095, 12'd4095, 12'hFFF,  12'hFFF,  12'hFFF,  64};
        tab[6] = '{8'd0,   12'd4095, 12'd4095, 12'd4095, 12'd4095, 12'd4095, 12'd4095, 12'd4095, 64};
        tab[7] = '{8'd1,   12'd16,   12'd16,   12'd16,   12'd16,   12'hFFF,  12'hFFF,  12'hFFF,  64};

        use_tab = 1'b1;
        for (int i = 0; i < 8; i++) begin
            th = tab[i].th;
            c_g1 = tab[i].g1; c_r = tab[i].r; c_b = tab[i].b; c_g2 = tab[i].g2;
            tab_rgb = {tab[i].er, tab[i].eg, tab[i].eb};
            clear_frame();
            feed_row(0, tab[i].len, 0, 0);
            s0 = strobes;
            feed_row(1, tab[i].len, 0, 0);
            drain();
            check("row1_strobes", strobes - s0, tab[i].len / 2);
        end
        use_tab = 1'b0;

        // Random frame, gap-free, then the same frame with valid bubbles.
        th = 8'd0;
        clear_frame();
        s0 = strobes;
        for (int y = 0; y < 4; y++) feed_row(y, LW, 1, 0);
        drain();
        n_nogap = strobes - s0;
        check("nogap_strobes", n_nogap, 1280);

        clear_frame();
        s0 = strobes;
        for (int y = 0; y < 4; y++) feed_row(y, LW, 1, 20);
        drain();
        n_gap = strobes - s0;
        check("gap_strobes", n_gap, n_nogap);

        // Random frame binarized with a threshold near the mean luma.
        th = 8'($urandom_range(100, 160));
        clear_frame();
        for (int y = 0; y < 4; y++) feed_row(y, LW, 1, 10);
        drain();

        // Reset mid-row 1: the emitting pixel still in flight must not strobe.
        th = 8'd0;
        clear_frame();
        feed_row(0, LW, 1, 0);
        feed_row(1, 602, 1, 0);
        @(posedge iCLK);
        #1;
        iDVAL = 1'b0;
        iRST  = 1'b1;
        @(posedge iCLK);
        #1;
        iRST = 1'b0;
        exp_q.delete();
        exp_cyc.delete();
        hold_ref = '0;
        hold_known = 1'b1;
        @(negedge iCLK);
        check("rst_mid_dval", oDVAL, 0);
        check("rst_mid_rgb", {oRed, oGreen, oBlue}, 36'd0);
        repeat (6) idle();
        clear_frame();
        feed_row(0, 200, 1, 0);
        feed_row(1, 200, 1, 0);
        drain();

        // Short row 0 (1000 pixels): the x==0 pixel of row 1 realigns the pointer.
        clear_frame();
        feed_row(0, 1000, 1, 0);
        for (int y = 1; y < 4; y++) feed_row(y, LW, 1, 0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
